// File: rtl/serial_uart.sv
`timescale 1ns/1ps
// serial_uart: 8N1 UART with show-ahead RX FIFO and TX FIFO
// bridging the processor serial byte port to the board pins.
module serial_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       uart_tx,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_wren,
    input  logic       cpu_rden,
    output logic [7:0] cpu_rdata,
    output logic       cpu_rx_valid,
    output logic       cpu_tx_ready,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // ---------------- RX ----------------
    logic [2:0]        rx_sync_q;
    logic              rx_s;
    logic              rx_fall;

    state_e            rx_state_q, rx_state_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_push;
    logic              rx_ferr_set;

    logic [7:0]        rx_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] rx_wp_q, rx_wp_d;
    logic [ADDR_W-1:0] rx_rp_q, rx_rp_d;
    logic [ADDR_W:0]   rx_count_q, rx_count_d;
    logic              rx_ovr_q, rx_ovr_d;
    logic              rx_ferr_q, rx_ferr_d;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_wr;

    // Two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_sync_q <= 3'b111;
        end else begin
            rx_sync_q <= {rx_sync_q[1:0], uart_rx};
        end
    end

    assign rx_s    = rx_sync_q[1];
    assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];

    // RX frame FSM: mid-bit sampling timed from the start edge
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        rx_ferr_set = 1'b0;
        unique case (rx_state_q)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                end
            end
            S_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d    = '0;
                    rx_state_d  = S_IDLE;
                    rx_push     = rx_s;
                    rx_ferr_set = ~rx_s;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // RX FIFO bookkeeping; a same-cycle pop frees the slot for a push
    always_comb begin
        rx_pop     = cpu_rden & (rx_count_q != '0);
        rx_full    = (rx_count_q == FULL_CNT);
        rx_wr      = rx_push & (~rx_full | rx_pop);
        rx_wp_d    = rx_wp_q + ADDR_W'(rx_wr);
        rx_rp_d    = rx_rp_q + ADDR_W'(rx_pop);
        rx_count_d = rx_count_q + (ADDR_W + 1)'(rx_wr)
                   - (ADDR_W + 1)'(rx_pop);
        rx_ovr_d   = rx_ovr_q | (rx_push & rx_full & ~rx_pop);
        rx_ferr_d  = rx_ferr_q | rx_ferr_set;
    end

    // RX state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_count_q <= '0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_count_q <= rx_count_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // RX storage; contents are only observed while the count says valid
    always_ff @(posedge clock) begin
        if (rx_wr) begin
            rx_mem_q[rx_wp_q] <= rx_shift_q;
        end
    end

    assign cpu_rx_valid = (rx_count_q != '0);
    assign cpu_rdata    = cpu_rx_valid ? rx_mem_q[rx_rp_q] : 8'h00;
    assign rx_overrun   = rx_ovr_q;
    assign rx_frame_err = rx_ferr_q;

    // ---------------- TX ----------------
    state_e            tx_state_q, tx_state_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              tx_q, tx_d;
    logic              tx_pop;

    logic [7:0]        tx_mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] tx_wp_q, tx_wp_d;
    logic [ADDR_W-1:0] tx_rp_q, tx_rp_d;
    logic [ADDR_W:0]   tx_count_q, tx_count_d;
    logic              tx_wr;

    // TX frame FSM: IDLE pops the head and starts the frame immediately
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_count_q != '0) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_mem_q[tx_rp_q];
                    tx_d       = 1'b0;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    // TX FIFO bookkeeping; a full FIFO rejects writes even during a pop
    always_comb begin
        tx_wr      = cpu_wren & (tx_count_q != FULL_CNT);
        tx_wp_d    = tx_wp_q + ADDR_W'(tx_wr);
        tx_rp_d    = tx_rp_q + ADDR_W'(tx_pop);
        tx_count_d = tx_count_q + (ADDR_W + 1)'(tx_wr)
                   - (ADDR_W + 1)'(tx_pop);
    end

    // TX state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_count_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_count_q <= tx_count_d;
        end
    end

    // TX storage
    always_ff @(posedge clock) begin
        if (tx_wr) begin
            tx_mem_q[tx_wp_q] <= cpu_wdata;
        end
    end

    assign uart_tx      = tx_q;
    assign cpu_tx_ready = (tx_count_q != FULL_CNT);

endmodule

// File: tb/tb_serial_uart.sv
`timescale 1ns/1ps
// tb_serial_uart: randomized bench with a frame-level reference
// model for both directions of serial_uart.
module tb_serial_uart;

    localparam int CPB = 4;
    localparam int FW  = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic [7:0] cpu_wdata = 8'h00;
    logic       cpu_wren = 1'b0;
    logic       cpu_rden = 1'b0;
    logic [7:0] cpu_rdata;
    logic       cpu_rx_valid;
    logic       cpu_tx_ready;
    logic       rx_overrun;
    logic       rx_frame_err;

    serial_uart #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (16),
        .ADDR_W      (4)
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .uart_tx     (uart_tx),
        .cpu_wdata   (cpu_wdata),
        .cpu_wren    (cpu_wren),
        .cpu_rden    (cpu_rden),
        .cpu_rdata   (cpu_rdata),
        .cpu_rx_valid(cpu_rx_valid),
        .cpu_tx_ready(cpu_tx_ready),
        .rx_overrun  (rx_overrun),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    logic       ovr_exp = 1'b0;
    logic       ferr_exp = 1'b0;
    int         frames_seen = 0;

    function automatic logic [FW-1:0] frame_bits(input logic [7:0] b);
        logic [9:0]    f;
        logic [FW-1:0] r;
        f = {1'b1, b, 1'b0};
        for (int k = 0; k < FW; k++) r[k] = f[k / CPB];
        return r;
    endfunction

    // Line monitor: captures every TX frame cycle by cycle
    logic [FW-1:0] mon_bits;
    int            mon_n = 0;
    bit            mon_active = 0;
    bit            mon_has = 0;
    logic [7:0]    mon_byte;

    always @(negedge clk) begin
        if (reset) begin
            mon_active = 0;
        end else if (!mon_active) begin
            if (uart_tx == 1'b0) begin
                mon_active = 1;
                mon_bits = '1;
                mon_bits[0] = uart_tx;
                mon_n = 1;
                chk("tx_frame_expected", 64'(tx_exp.size() != 0), 1);
                mon_has = (tx_exp.size() != 0);
                if (mon_has) mon_byte = tx_exp.pop_front();
            end
        end else begin
            mon_bits[mon_n] = uart_tx;
            mon_n++;
            if (mon_n == FW) begin
                mon_active = 0;
                frames_seen++;
                if (mon_has) chk("tx_frame", mon_bits, frame_bits(mon_byte));
            end
        end
    end

    task automatic rx_send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        if (stop) begin
            if (rx_exp.size() < 16) rx_exp.push_back(b);
            else ovr_exp = 1'b1;
        end else begin
            ferr_exp = 1'b1;
        end
    endtask

    task automatic rx_pop();
        logic [7:0] e;
        e = rx_exp.pop_front();
        chk("rx_valid", cpu_rx_valid, 1);
        chk("rx_data", cpu_rdata, e);
        cpu_rden = 1'b1;
        @(negedge clk);
        cpu_rden = 1'b0;
    endtask

    task automatic rx_state(input string tag);
        chk({tag, "_valid"}, cpu_rx_valid, 64'(rx_exp.size() != 0));
        chk({tag, "_overrun"}, rx_overrun, ovr_exp);
        chk({tag, "_frame_err"}, rx_frame_err, ferr_exp);
    endtask

    task automatic tx_write(input logic [7:0] b);
        cpu_wdata = b;
        cpu_wren = 1'b1;
        @(negedge clk);
        cpu_wren = 1'b0;
    endtask

    task automatic tx_drain();
        int n;
        n = 0;
        while ((tx_exp.size() != 0 || mon_active) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_drain_left", tx_exp.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx_exp.delete();
        tx_exp.delete();
        ovr_exp = 1'b0;
        ferr_exp = 1'b0;
        @(negedge clk);
        chk("rst_tx_high", uart_tx, 1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_rx_valid", cpu_rx_valid, 0);
        chk("rst_tx_ready", cpu_tx_ready, 1);
        chk("rst_rdata", cpu_rdata, 8'h00);
        chk("rst_overrun", rx_overrun, 0);
        chk("rst_frame_err", rx_frame_err, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // TX single frame 0xA5 with start latency
        tx_exp.push_back(8'hA5);
        tx_write(8'hA5);
        chk("tx_before_start", uart_tx, 1);
        @(negedge clk);
        chk("tx_start_low", uart_tx, 0);
        tx_drain();
        chk("tx_idle_high", uart_tx, 1);
        chk("tx_frames_a5", frames_seen, 1);

        // RX single frame 0x3C, pop, empty view
        rx_send(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        rx_pop();
        chk("rx_after_pop_valid", cpu_rx_valid, 0);
        chk("rx_after_pop_rdata", cpu_rdata, 8'h00);
        cpu_rden = 1'b1;
        @(negedge clk);
        cpu_rden = 1'b0;
        chk("rx_empty_rden_valid", cpu_rx_valid, 0);

        // One-cycle glitch is rejected
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (12) @(negedge clk);
        rx_state("glitch");

        // Stop bit low -> frame error, nothing pushed
        rx_send(8'h55, 1'b0);
        repeat (6) @(negedge clk);
        rx_state("frame_err");

        // Overrun: 17 frames into a 16-deep FIFO
        do_reset();
        rx_state("post_reset");
        for (int i = 0; i <= 16; i++) rx_send(8'(i), 1'b1);
        repeat (4) @(negedge clk);
        rx_state("overrun");
        while (rx_exp.size() != 0) rx_pop();
        rx_state("overrun_drained");
        chk("overrun_rdata_empty", cpu_rdata, 8'h00);

        // TX backpressure: 18 back-to-back writes
        do_reset();
        f0 = frames_seen;
        for (int i = 0; i < 18; i++) begin
            b = 8'($urandom);
            if (i == 16) chk("tx_ready_before_16", cpu_tx_ready, 1);
            if (i == 17) chk("tx_ready_full", cpu_tx_ready, 0);
            if (i < 17) tx_exp.push_back(b);
            cpu_wdata = b;
            cpu_wren = 1'b1;
            @(negedge clk);
        end
        cpu_wren = 1'b0;
        tx_drain();
        chk("tx_frames_17", frames_seen - f0, 17);

        // Reset mid-frame abandons the line and the FIFO
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            tx_exp.push_back(b);
            tx_write(b);
        end
        repeat (15) @(negedge clk);
        do_reset();
        f0 = frames_seen;
        repeat (200) @(negedge clk);
        chk("reset_no_frames", frames_seen - f0, 0);
        chk("reset_tx_high", uart_tx, 1);
        chk("reset_tx_ready", cpu_tx_ready, 1);

        // Randomized concurrent RX and TX traffic
        for (int r = 0; r < 3; r++) begin
            fork
                begin
                    int n;
                    logic good;
                    n = $urandom_range(1, 18);
                    for (int i = 0; i < n; i++) begin
                        good = ($urandom_range(0, 7) != 0);
                        rx_send(8'($urandom), good);
                        if (good) repeat ($urandom_range(0, 3)) @(negedge clk);
                        else repeat ($urandom_range(2, 4)) @(negedge clk);
                    end
                end
                begin
                    logic [7:0] wb;
                    for (int k = 0; k < 10; k++) begin
                        repeat ($urandom_range(0, 30)) @(negedge clk);
                        if (cpu_tx_ready) begin
                            wb = 8'($urandom);
                            tx_exp.push_back(wb);
                            tx_write(wb);
                        end
                    end
                end
            join
            repeat (6) @(negedge clk);
            rx_state("rand_rx");
            while (rx_exp.size() != 0) rx_pop();
            rx_state("rand_drained");
            tx_drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
